lab2_proc_imul_seq_ctrl: RTL and testbench

LAB2_PROC_IMUL_SEQ_CTRL -- requirements
Module: lab2_proc_imul_seq_ctrl

---
 rtl/lab2_proc_imul_seq_ctrl.sv | 109 ++++++++++
 tb/tb_lab2_proc_imul_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_imul_seq_ctrl.sv
// Control unit of the iterative shift-and-add multiplier: IDLE -> CALC -> DONE.
// Define LAB2_PROC_IMUL_EARLY_EXIT_EN to leave CALC as soon as the shifted B register is zero.
module lab2_proc_imul_seq_ctrl #(
  parameter int unsigned p_nbits = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic req_val,
  output logic req_rdy,
  output logic resp_val,
  input  logic resp_rdy,
  input  logic b_lsb,
  input  logic b_zero,
  output logic a_mux_sel,
  output logic b_mux_sel,
  output logic result_mux_sel,
  output logic add_mux_sel,
  output logic result_en,
  output logic busy
);

  localparam int unsigned CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;
  localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          calc_done;

`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
  assign calc_done = (cnt == LAST) || b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign calc_done     = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter only advances while staying in CALC, so it never passes LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_val) begin
          state_nxt = CALC;
          cnt_nxt   = '0;
        end
      end
      CALC: begin
        if (calc_done) state_nxt = DONE;
        else           cnt_nxt   = cnt + CW'(1);
      end
      DONE: begin
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_rdy        = 1'b0;
    resp_val       = 1'b0;
    a_mux_sel      = 1'b0;
    b_mux_sel      = 1'b0;
    result_mux_sel = 1'b0;
    add_mux_sel    = 1'b0;
    result_en      = 1'b0;
    unique case (state)
      IDLE: begin
        req_rdy   = 1'b1;
        result_en = 1'b1;
      end
      CALC: begin
        a_mux_sel      = 1'b1;
        b_mux_sel      = 1'b1;
        result_mux_sel = 1'b1;
        result_en      = 1'b1;
        add_mux_sel    = b_lsb;
      end
      DONE: begin
        resp_val  = 1'b1;
        a_mux_sel = 1'b1;
        b_mux_sel = 1'b1;
      end
      default: begin
        req_rdy   = 1'b1;
        result_en = 1'b1;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lab2_proc_imul_seq_ctrl.sv
// Bench for lab2_proc_imul_seq_ctrl: a behavioural shift-and-add datapath closes the loop;
// a scoreboard queue holds expected products and latencies, checked by a monitor process.
module tb_lab2_proc_imul_seq_ctrl;

  localparam int unsigned NB = 32;

  logic clk = 1'b0;
  logic reset, req_val, req_rdy, resp_val, resp_rdy, b_lsb, b_zero;
  logic a_mux_sel, b_mux_sel, result_mux_sel, add_mux_sel, result_en, busy;
  logic [NB-1:0] opa, opb, a_reg, b_reg, res;

  always #5 clk = ~clk;

  lab2_proc_imul_seq_ctrl #(.p_nbits(NB)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .b_lsb(b_lsb), .b_zero(b_zero),
    .a_mux_sel(a_mux_sel), .b_mux_sel(b_mux_sel), .result_mux_sel(result_mux_sel),
    .add_mux_sel(add_mux_sel), .result_en(result_en), .busy(busy)
  );

  // Datapath model driven by the control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
      res   <= '0;
    end else begin
      a_reg <= a_mux_sel ? (a_reg << 1) : opa;
      b_reg <= b_mux_sel ? (b_reg >> 1) : opb;
      if (result_en) res <= result_mux_sel ? (add_mux_sel ? res + a_reg : res) : '0;
    end
  end
  assign b_lsb  = b_reg[0];
  assign b_zero = (b_reg == '0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Number of CALC cycles the sequencer should spend for multiplier b
  function automatic int exp_calc(input logic [NB-1:0] b);
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
    int n = 0;
    logic [NB-1:0] t = b;
    while (t != '0) begin
      t = t >> 1;
      n++;
    end
    n = n + 1;
    if (n > NB) n = NB;
    return n;
`else
    return NB;
`endif
  endfunction

  typedef struct {
    logic [NB-1:0] prod;
    int            lat;
  } exp_t;
  exp_t sb[$];

  int   cyc = 0;
  int   hs_cyc = 0;
  int   calc_cnt = 0;
  int   add_cnt = 0;
  logic prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency on each new response, product on each response handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (req_val && req_rdy) begin
        hs_cyc   = cyc;
        calc_cnt = 0;
        add_cnt  = 0;
      end
      if (busy && !resp_val) begin
        calc_cnt++;
        if (add_mux_sel) add_cnt++;
      end else begin
        check("add_mux_sel_outside_calc", {63'd0, add_mux_sel}, 64'd0);
      end
      if (resp_val && !prev_rv) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got resp_val=1 required no response");
        end else begin
          check("latency", 64'(cyc - hs_cyc), 64'(sb[0].lat));
        end
      end
      if (resp_val && resp_rdy && sb.size() != 0) begin
        e = sb.pop_front();
        check("product", {32'd0, res}, {32'd0, e.prod});
      end
      prev_rv = resp_val;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [NB-1:0] prod, input bit expect_resp);
    exp_t e;
    bit   ok = 1'b0;
    @(posedge clk); #1;
    opa = a;
    opb = b;
    req_val = 1'b1;
    if (expect_resp) begin
      e.prod = prod;
      e.lat  = exp_calc(b) + 1;
      sb.push_back(e);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic wait_rv(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 64'd0, 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [NB-1:0] held;
    bit seen;
    bit ok;

    reset = 1'b0; req_val = 1'b0; resp_rdy = 1'b1; opa = '0; opb = '0;
    #1;
    check("rst_req_rdy", {63'd0, req_rdy}, 64'd1);
    check("rst_resp_val", {63'd0, resp_val}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_add_mux_sel", {63'd0, add_mux_sel}, 64'd0);
    check("rst_result_en", {63'd0, result_en}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 7*6 with consumer ready, then IDLE the cycle after the response
    issue(32'd7, 32'd6, 32'd42, 1'b1);
    wait_rv("t1_wait_resp");
    @(negedge clk);
    check("t1_idle_after_resp", {63'd0, busy}, 64'd0);
    check("t1_req_rdy_after_resp", {63'd0, req_rdy}, 64'd1);

    // all-ones squared: low bits are 1, every CALC cycle adds
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_idle("t2_wait_idle");
    check("t2_calc_cycles", 64'(calc_cnt), 64'(exp_calc(32'hFFFF_FFFF)));
    check("t2_add_cycles", 64'(add_cnt), 64'd32);

    // consumer stalls in DONE
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    issue(32'd100, 32'd25, 32'd2500, 1'b1);
    wait_rv("t3_wait_resp");
    held = res;
    for (int i = 0; i < 5; i++) begin
      check("t3_resp_val_held", {63'd0, resp_val}, 64'd1);
      check("t3_product_stable", {32'd0, res}, {32'd0, held});
      check("t3_req_rdy_low", {63'd0, req_rdy}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    wait_idle("t3_wait_idle");

    // reset at CALC cycle 10 aborts the operation
    issue(32'd11, 32'd13, 32'd143, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t4_busy_in_reset", {63'd0, busy}, 64'd0);
    check("t4_req_rdy_in_reset", {63'd0, req_rdy}, 64'd1);
    check("t4_resp_val_in_reset", {63'd0, resp_val}, 64'd0);
    check("t4_add_mux_in_reset", {63'd0, add_mux_sel}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_val) seen = 1'b1;
    end
    check("t4_no_resp_after_abort", {63'd0, seen}, 64'd0);
    issue(32'd3, 32'd5, 32'd15, 1'b1);
    wait_idle("t4_wait_idle");

    // short multiplier: CALC length depends on early-exit build option
    issue(32'd9, 32'd4, 32'd36, 1'b1);
    wait_idle("t5_wait_idle");
    check("t5_calc_cycles", 64'(calc_cnt), 64'(exp_calc(32'd4)));

    // back-to-back with req_val held high
    @(posedge clk); #1;
    opa = 32'd5; opb = 32'd5; req_val = 1'b1;
    e.prod = 32'd25; e.lat = exp_calc(32'd5) + 1; sb.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("t6_first_accept", 64'd0, 64'd1);
    opa = 32'd6; opb = 32'd7;
    e.prod = 32'd42; e.lat = exp_calc(32'd7) + 1; sb.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (resp_val && resp_rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("t6_first_resp", 64'd0, 64'd1);
    check("t6_no_accept_on_resp", {63'd0, req_rdy}, 64'd0);
    @(negedge clk);
    check("t6_idle_gap_busy", {63'd0, busy}, 64'd0);
    check("t6_idle_gap_req_rdy", {63'd0, req_rdy}, 64'd1);
    @(negedge clk);
    check("t6_second_accepted", {63'd0, busy}, 64'd1);
    check("t6_second_not_done", {63'd0, resp_val}, 64'd0);
    @(posedge clk); #1;
    req_val = 1'b0;
    wait_idle("t6_wait_idle");

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before 500000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
